scanline_sequencer: RTL and testbench

Per-scanline render controller for the VGA display path. It sequences the tile engine and then the sprite engine into the draw half of the double-buffered linebuffer, and flips the display/draw buffer select once per rendered line. It detects lines whose rendering is not finished by the flip point and counts them, and raises a one-cycle vertical-blank pulse for the host interface. It sits in `vga_top` between `vga_counters` and the tile/sprite engines, replacing the ad-hoc start/switch logic.

---
 rtl/scanline_sequencer.sv | 142 ++++++++++++++
 tb/tb_scanline_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/scanline_sequencer.sv
// Per-scanline render controller: starts the tile then sprite engine at line start,
// flips the linebuffer select at SWITCH_H, and tracks overrun lines and vertical blank.
module scanline_sequencer #(
   parameter int unsigned HTOTAL   = 1600,
   parameter int unsigned VTOTAL   = 525,
   parameter int unsigned VACTIVE  = 480,
   parameter int unsigned SWITCH_H = 1590
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] hcount,
   input  logic [9:0]  vcount,
   input  logic        enable,
   input  logic        clr_status,
   input  logic        tile_done,
   input  logic        sprite_done,
   output logic        tile_start,
   output logic        sprite_start,
   output logic        switch,
   output logic [9:0]  render_line,
   output logic        busy,
   output logic        overrun,
   output logic [15:0] overrun_count,
   output logic        vblank_pulse
);

   localparam int unsigned HW = 11;
   localparam int unsigned VW = 10;
   localparam int unsigned CW = 16;

   typedef enum logic [2:0] {
      IDLE, T_START, T_GUARD, T_WAIT, S_START, S_GUARD, S_WAIT, DONE
   } state_t;

   state_t state_q, state_d;

   logic          tile_start_q, tile_start_d;
   logic          sprite_start_q, sprite_start_d;
   logic          switch_q, switch_d;
   logic [VW-1:0] render_line_q, render_line_d;
   logic          busy_q, busy_d;
   logic          overrun_q, overrun_d;
   logic [CW-1:0] overrun_count_q, overrun_count_d;
   logic          vblank_pulse_q, vblank_pulse_d;
   logic          line_active_q, line_active_d;

   logic          render_row_c;
   logic          start_c;
   logic          flip_c;
   logic          overrun_c;
   logic [VW-1:0] next_row_c;

   // Line qualification; the flip only applies to lines whose start was accepted.
   assign render_row_c = (vcount < VW'(VACTIVE - 1)) || (vcount == VW'(VTOTAL - 1));
   assign start_c      = (hcount == HW'(0)) && render_row_c && enable && (state_q == IDLE);
   assign flip_c       = (hcount == HW'(SWITCH_H)) && line_active_q;
   assign overrun_c    = flip_c && (state_q != DONE) && (state_q != IDLE);
   assign next_row_c   = (vcount == VW'(VTOTAL - 1)) ? VW'(0) : vcount + VW'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // The flip point overrides every other transition and abandons an unfinished line.
   always_comb begin
      state_d = state_q;
      if (flip_c) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE:    if (start_c) state_d = T_START;
            T_START: state_d = T_GUARD;
            T_GUARD: state_d = T_WAIT;
            T_WAIT:  if (tile_done) state_d = S_START;
            S_START: state_d = S_GUARD;
            S_GUARD: state_d = S_WAIT;
            S_WAIT:  if (sprite_done) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Output decode from the next state so pulses and busy line up with the state register.
   always_comb begin
      tile_start_d    = (state_d == T_START);
      sprite_start_d  = (state_d == S_START);
      busy_d          = (state_d != IDLE) && (state_d != DONE);
      switch_d        = switch_q ^ flip_c;
      render_line_d   = start_c ? next_row_c : render_line_q;
      line_active_d   = line_active_q;
      overrun_d       = overrun_q;
      overrun_count_d = overrun_count_q;
      vblank_pulse_d  = (hcount == HW'(0)) && (vcount == VW'(VACTIVE));
      if (flip_c)  line_active_d = 1'b0;
      if (start_c) line_active_d = 1'b1;
      // A simultaneous clear loses to the overrun, leaving a count of one.
      if (overrun_c) begin
         overrun_d = 1'b1;
         if (clr_status)                  overrun_count_d = CW'(1);
         else if (overrun_count_q != '1)  overrun_count_d = overrun_count_q + CW'(1);
      end else if (clr_status) begin
         overrun_d       = 1'b0;
         overrun_count_d = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tile_start_q    <= 1'b0;
         sprite_start_q  <= 1'b0;
         switch_q        <= 1'b0;
         render_line_q   <= '0;
         busy_q          <= 1'b0;
         overrun_q       <= 1'b0;
         overrun_count_q <= '0;
         vblank_pulse_q  <= 1'b0;
         line_active_q   <= 1'b0;
      end else begin
         tile_start_q    <= tile_start_d;
         sprite_start_q  <= sprite_start_d;
         switch_q        <= switch_d;
         render_line_q   <= render_line_d;
         busy_q          <= busy_d;
         overrun_q       <= overrun_d;
         overrun_count_q <= overrun_count_d;
         vblank_pulse_q  <= vblank_pulse_d;
         line_active_q   <= line_active_d;
      end
   end

   assign tile_start    = tile_start_q;
   assign sprite_start  = sprite_start_q;
   assign switch        = switch_q;
   assign render_line   = render_line_q;
   assign busy          = busy_q;
   assign overrun       = overrun_q;
   assign overrun_count = overrun_count_q;
   assign vblank_pulse  = vblank_pulse_q;

endmodule

// File: tb/tb_scanline_sequencer.sv
// Line-by-line directed bench for scanline_sequencer using a shrunken timing raster
// and simple latency models of the tile and sprite engines.
module tb_scanline_sequencer;

   localparam int HT = 40;
   localparam int VT = 12;
   localparam int VA = 8;
   localparam int SH = 30;

   logic        clk = 1'b0;
   logic        reset;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic        enable;
   logic        clr_status;
   logic        tile_done;
   logic        sprite_done;
   logic        tile_start;
   logic        sprite_start;
   logic        switch;
   logic [9:0]  render_line;
   logic        busy;
   logic        overrun;
   logic [15:0] overrun_count;
   logic        vblank_pulse;

   scanline_sequencer #(.HTOTAL(HT), .VTOTAL(VT), .VACTIVE(VA), .SWITCH_H(SH)) dut (
      .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount), .enable(enable),
      .clr_status(clr_status), .tile_done(tile_done), .sprite_done(sprite_done),
      .tile_start(tile_start), .sprite_start(sprite_start), .switch(switch),
      .render_line(render_line), .busy(busy), .overrun(overrun),
      .overrun_count(overrun_count), .vblank_pulse(vblank_pulse)
   );

   always #5 clk = ~clk;

   typedef struct {
      int v; bit en; bit en_mid; int tl; int sl; int clr_h; bit force_sat;
      int tile_n; int tile_h; int spr_n; int spr_h; int idle_h;
      bit tog; int rl; bit ov; int cnt; int vb_n;
   } vec_t;

   int n_chk = 0;
   int n_err = 0;
   int cur_tl, cur_sl, tcnt, scnt;
   int o_tile_n, o_tile_h, o_spr_n, o_spr_h, o_idle_h, o_vb_n, o_vb_h, o_tog_n, o_tog_h;
   bit exp_sw;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // One clock: drive inputs for hcount h, sample outputs just after the edge (cycle h+1).
   task automatic cyc(input int h, input int v, input bit en, input bit clr);
      logic sw_prev;
      hcount = 11'(h); vcount = 10'(v); enable = en; clr_status = clr;
      sw_prev = switch;
      @(posedge clk); #1;
      if (tile_start) begin o_tile_n++; o_tile_h = h + 1; end
      if (sprite_start) begin o_spr_n++; o_spr_h = h + 1; end
      if (vblank_pulse) begin o_vb_n++; o_vb_h = h + 1; end
      if (switch != sw_prev) begin o_tog_n++; o_tog_h = h + 1; end
      if (o_tile_n > 0 && !busy && o_idle_h == 0) o_idle_h = h + 1;
      if (tile_start) begin
         if (cur_tl == 0) tile_done = 1'b1; else begin tile_done = 1'b0; tcnt = cur_tl; end
      end else if (tcnt > 0) begin
         tcnt--; if (tcnt == 0) tile_done = 1'b1;
      end
      if (sprite_start) begin
         if (cur_sl == 0) sprite_done = 1'b1; else begin sprite_done = 1'b0; scnt = cur_sl; end
      end else if (scnt > 0) begin
         scnt--; if (scnt == 0) sprite_done = 1'b1;
      end
   endtask

   task automatic clear_obs();
      o_tile_n = 0; o_tile_h = 0; o_spr_n = 0; o_spr_h = 0; o_idle_h = 0;
      o_vb_n = 0; o_vb_h = 0; o_tog_n = 0; o_tog_h = 0;
   endtask

   task automatic run_vec(input vec_t r, input int idx);
      string p;
      p = $sformatf("v%0d", idx);
      cur_tl = r.tl; cur_sl = r.sl;
      if (r.force_sat) begin
         force dut.overrun_count_d = 16'hFFFF;
         @(posedge clk); #1;
         release dut.overrun_count_d;
         chk({p, "_sat_preload"}, int'(overrun_count), 32'hFFFF);
      end
      clear_obs();
      for (int h = 0; h < HT; h++)
         cyc(h, r.v, (r.en_mid && h >= 5) ? 1'b1 : r.en, (r.clr_h != 0 && h == r.clr_h));
      if (r.tog) exp_sw = ~exp_sw;
      chk({p, "_tile_n"}, o_tile_n, r.tile_n);
      chk({p, "_tile_h"}, o_tile_h, r.tile_h);
      chk({p, "_spr_n"}, o_spr_n, r.spr_n);
      chk({p, "_spr_h"}, o_spr_h, r.spr_h);
      chk({p, "_idle_h"}, o_idle_h, r.idle_h);
      chk({p, "_tog_n"}, o_tog_n, r.tog ? 1 : 0);
      chk({p, "_tog_h"}, o_tog_h, r.tog ? SH + 1 : 0);
      chk({p, "_switch"}, int'(switch), int'(exp_sw));
      chk({p, "_render_line"}, int'(render_line), r.rl);
      chk({p, "_overrun"}, int'(overrun), int'(r.ov));
      chk({p, "_count"}, int'(overrun_count), r.cnt);
      chk({p, "_vb_n"}, o_vb_n, r.vb_n);
      chk({p, "_vb_h"}, o_vb_h, r.vb_n != 0 ? 1 : 0);
      chk({p, "_busy_end"}, int'(busy), 0);
   endtask

   vec_t vecs[15];
   vec_t post;

   initial begin
      //          v  en em tl   sl  clr fs  tn th sn sh idle tog rl ov cnt     vb
      vecs[0]  = '{0,  1, 0, 10, 10,   0, 0, 1, 1, 1, 12, 23, 1, 1, 0, 0,      0};
      vecs[1]  = '{1,  1, 0,  0,  0,   0, 0, 1, 1, 1,  4,  7, 1, 2, 0, 0,      0};
      vecs[2]  = '{2,  0, 0, 10, 10,   0, 0, 0, 0, 0,  0,  0, 0, 2, 0, 0,      0};
      vecs[3]  = '{6,  1, 0,  3,  3,   0, 0, 1, 1, 1,  5,  9, 1, 7, 0, 0,      0};
      vecs[4]  = '{7,  1, 0, 10, 10,   0, 0, 0, 0, 0,  0,  0, 0, 7, 0, 0,      0};
      vecs[5]  = '{8,  1, 0, 10, 10,   0, 0, 0, 0, 0,  0,  0, 0, 7, 0, 0,      1};
      vecs[6]  = '{10, 1, 0, 10, 10,   0, 0, 0, 0, 0,  0,  0, 0, 7, 0, 0,      0};
      vecs[7]  = '{11, 1, 0, 10, 10,   0, 0, 1, 1, 1, 12, 23, 1, 0, 0, 0,      0};
      vecs[8]  = '{3,  1, 0,  2, 1000, 0, 0, 1, 1, 1,  4, 31, 1, 4, 1, 1,      0};
      vecs[9]  = '{4,  1, 0, 10, 10,   0, 0, 1, 1, 1, 12, 23, 1, 5, 1, 1,      0};
      vecs[10] = '{5,  0, 1, 10, 10,   0, 0, 0, 0, 0,  0,  0, 0, 5, 1, 1,      0};
      vecs[11] = '{5,  1, 0, 10, 1000, 0, 1, 1, 1, 1, 12, 31, 1, 6, 1, 65535,  0};
      vecs[12] = '{6,  1, 0, 10, 10,  10, 0, 1, 1, 1, 12, 23, 1, 7, 0, 0,      0};
      vecs[13] = '{0,  1, 0,  0, 1000, SH, 0, 1, 1, 1,  4, 31, 1, 1, 1, 1,     0};
      vecs[14] = '{3,  1, 0, 10, 10,   0, 0, 1, 1, 1, 12, 23, 1, 4, 0, 0,      0};

      reset = 1'b1; hcount = 11'(HT - 1); vcount = '0; enable = 1'b0; clr_status = 1'b0;
      tile_done = 1'b1; sprite_done = 1'b1; tcnt = 0; scnt = 0; cur_tl = 0; cur_sl = 0;
      exp_sw = 1'b0;
      clear_obs();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_switch", int'(switch), 0);
      chk("rst_render_line", int'(render_line), 0);
      chk("rst_overrun", int'(overrun), 0);
      chk("rst_count", int'(overrun_count), 0);
      chk("rst_tile_start", int'(tile_start), 0);
      reset = 1'b0;
      cyc(HT - 1, VT - 2, 1'b0, 1'b0);

      for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

      // Reset asserted between clock edges while the sprite engine is outstanding.
      cur_tl = 10; cur_sl = 1000;
      clear_obs();
      for (int h = 0; h < 20; h++) cyc(h, 2, 1'b1, 1'b0);
      chk("pre_rst_busy", int'(busy), 1);
      chk("pre_rst_spr_n", o_spr_n, 1);
      #2 reset = 1'b1;
      #1;
      chk("async_busy", int'(busy), 0);
      chk("async_switch", int'(switch), 0);
      chk("async_render_line", int'(render_line), 0);
      chk("async_overrun", int'(overrun), 0);
      chk("async_count", int'(overrun_count), 0);
      chk("async_tile_start", int'(tile_start), 0);
      chk("async_sprite_start", int'(sprite_start), 0);
      clear_obs();
      for (int h = 20; h < HT; h++) begin
         reset = (h < 25);
         cyc(h, 2, 1'b1, 1'b0);
      end
      chk("post_rst_tile_n", o_tile_n, 0);
      chk("post_rst_spr_n", o_spr_n, 0);
      chk("post_rst_switch", int'(switch), 0);
      exp_sw = 1'b0;
      post = vecs[14];
      run_vec(post, 14);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
